// File: rtl/uart_transceiver.sv
// Full-duplex UART: single-entry valid/ready TX and a FIFO-buffered RX path.
// Optional even parity in both directions when UART_PARITY_EN is defined.
module uart_transceiver #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_WIDTH    = 8,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overflow,
    output logic                  rx_frame_err
);
    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int AW    = $clog2(RX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Transmitter
    state_t                tx_state, tx_state_n;
    logic [CNT_W-1:0]      tx_cnt;
    logic [IDX_W-1:0]      tx_idx;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic                  tx_q;
    logic                  tx_bit_done;
    logic                  tx_last_fill;
`ifdef UART_PARITY_EN
    logic                  tx_par;
    assign tx_last_fill = tx_par;
`else
    assign tx_last_fill = 1'b1;
`endif

    assign tx          = tx_q;
    assign tx_ready    = (tx_state == S_IDLE);
    assign tx_bit_done = (tx_cnt == BIT_END);

    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_valid) tx_state_n = S_START;
            S_START:  if (tx_bit_done) tx_state_n = S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (tx_bit_done && tx_idx == LAST_IDX) tx_state_n = S_PARITY;
            S_PARITY: if (tx_bit_done) tx_state_n = S_STOP;
`else
            S_DATA:   if (tx_bit_done && tx_idx == LAST_IDX) tx_state_n = S_STOP;
`endif
            S_STOP:   if (tx_bit_done) tx_state_n = S_IDLE;
            default:  tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_q   <= 1'b1;
        end else if (tx_state == S_IDLE) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            if (tx_valid) tx_q <= 1'b0;
        end else if (tx_bit_done) begin
            tx_cnt <= '0;
            case (tx_state)
                S_START: tx_q <= tx_shreg[0];
                S_DATA: begin
                    tx_idx <= tx_idx + 1'b1;
                    tx_q   <= (tx_idx == LAST_IDX) ? tx_last_fill : tx_shreg[1];
                end
                default: tx_q <= 1'b1;
            endcase
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_state == S_IDLE && tx_valid) begin
            tx_shreg <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= even_parity(tx_data);
`endif
        end else if (tx_state == S_DATA && tx_bit_done) begin
            tx_shreg <= tx_shreg >> 1;
        end
    end

    // Receiver: synchroniser, then bit-centre sampling FSM
    logic rx_sync_p0, rx_sync_p1, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev    <= rx_sync_p1;
        end
    end

    state_t                rx_state, rx_state_n;
    logic [CNT_W-1:0]      rx_cnt;
    logic [IDX_W-1:0]      rx_idx;
    logic [DATA_WIDTH-1:0] rx_shreg;
    logic                  rx_bit_done, stop_sample, frame_ok, push_req, push, pop, full;
    logic [AW:0]           wptr, rptr;
    logic [DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
`ifdef UART_PARITY_EN
    logic                  rx_par_err;
    assign frame_ok = rx_sync_p1 && !rx_par_err;
`else
    assign frame_ok = rx_sync_p1;
`endif

    assign rx_bit_done = (rx_state == S_START) ? (rx_cnt == HALF_END) : (rx_cnt == BIT_END);
    assign stop_sample = (rx_state == S_STOP) && rx_bit_done;
    assign push_req    = stop_sample && frame_ok;
    assign rx_valid    = (wptr != rptr);
    assign pop         = rx_valid && rx_ready;
    assign full        = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push        = push_req && (!full || pop);
    assign rx_data     = rx_valid ? mem[rptr[AW-1:0]] : '0;

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_prev && !rx_sync_p1) rx_state_n = S_START;
            S_START:  if (rx_bit_done) rx_state_n = rx_sync_p1 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (rx_bit_done && rx_idx == LAST_IDX) rx_state_n = S_PARITY;
            S_PARITY: if (rx_bit_done) rx_state_n = S_STOP;
`else
            S_DATA:   if (rx_bit_done && rx_idx == LAST_IDX) rx_state_n = S_STOP;
`endif
            S_STOP:   if (rx_bit_done) rx_state_n = S_IDLE;
            default:  rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_frame_err <= 1'b0;
            rx_overflow  <= 1'b0;
            wptr         <= '0;
            rptr         <= '0;
`ifdef UART_PARITY_EN
            rx_par_err   <= 1'b0;
`endif
        end else begin
            rx_frame_err <= stop_sample && !frame_ok;
            rx_overflow  <= push_req && full && !pop;
            if (rx_state == S_IDLE || rx_bit_done) rx_cnt <= '0;
            else                                   rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_IDLE)                    rx_idx <= '0;
            else if (rx_state == S_DATA && rx_bit_done) rx_idx <= rx_idx + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_state == S_PARITY && rx_bit_done)
                rx_par_err <= rx_sync_p1 ^ even_parity(rx_shreg);
`endif
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_bit_done)
            rx_shreg <= {rx_sync_p1, rx_shreg[DATA_WIDTH-1:1]};
        if (push)
            mem[wptr[AW-1:0]] <= rx_shreg;
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at 16 clocks per bit; parity cases build with UART_PARITY_EN.
module tb_uart_transceiver;
    localparam int CPB   = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    logic          clk, rst, rx, tx, tx_valid, tx_ready, rx_valid, rx_ready;
    logic          rx_overflow, rx_frame_err;
    logic [DW-1:0] tx_data, rx_data;

    uart_transceiver #(
        .CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000),
        .DATA_WIDTH(DW), .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [DW-1:0] rx_q[$];
    logic          tx_bits_q[$];

    always @(posedge clk) begin
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overflow)  ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NBITS-1:0] make_frame(input logic [DW-1:0] d, input logic stop_bit);
        logic [NBITS-1:0] fr;
        fr        = '0;
        fr[DW:1]  = d;
`ifdef UART_PARITY_EN
        fr[DW+1]  = ^d;
`endif
        fr[NBITS-1] = stop_bit;
        return fr;
    endfunction

    task automatic tx_send(input logic [DW-1:0] d);
        logic [NBITS-1:0] fr;
        fr = make_frame(d, 1'b1);
        for (int b = 0; b < NBITS; b++) tx_bits_q.push_back(fr[b]);
        check($sformatf("tx_ready_before_%0h", d), tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check($sformatf("tx_ready_drop_%0h", d), tx_ready, 0);
        check($sformatf("tx_start_low_%0h", d), tx, 0);
        for (int k = 1; k <= NBITS * CPB; k++) begin
            @(posedge clk); #1;
            if (k % CPB == CPB / 2) begin
                if (tx_bits_q.size() == 0) check("tx_bits_q_empty", 1, 0);
                else check($sformatf("tx_%0h_bit%0d", d, k / CPB), tx, tx_bits_q.pop_front());
            end
            if (k == NBITS * CPB - 1) check($sformatf("tx_ready_busy_%0h", d), tx_ready, 0);
            if (k == NBITS * CPB)     check($sformatf("tx_ready_back_%0h", d), tx_ready, 1);
        end
    endtask

    task automatic rx_drive(input logic [NBITS-1:0] fr);
        for (int b = 0; b < NBITS; b++) begin
            rx = fr[b];
            repeat (CPB) @(posedge clk);
        end
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rx_pop(input string tag);
        logic [DW-1:0] exp;
        check({tag, "_valid"}, rx_valid, 1);
        if (rx_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            exp = rx_q.pop_front();
            check({tag, "_data"}, rx_data, exp);
        end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        int fe0, ov0;
        logic [NBITS-1:0] fr;
        rst = 1'b1; rx = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_rx_frame_err", rx_frame_err, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        tx_send(8'hA5);

        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_q.push_back(8'h3C);
        rx_drive(make_frame(8'h3C, 1'b1));
        check("rx3c_no_fe", fe_cnt - fe0, 0);
        check("rx3c_no_ov", ov_cnt - ov0, 0);
        rx_pop("rx3c");
        check("rx3c_empty_after_pop", rx_valid, 0);

        // Overfill: 17 frames with no consumer, last one must be dropped
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) rx_q.push_back(DW'(i));
            rx_drive(make_frame(DW'(i), 1'b1));
        end
        check("fill_ov_pulses", ov_cnt - ov0, 1);
        check("fill_no_fe", fe_cnt - fe0, 0);
        for (int i = 0; i < DEPTH; i++) rx_pop($sformatf("fifo_pop%0d", i));
        check("fifo_drained", rx_valid, 0);

        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_drive(make_frame(8'hFF, 1'b0));
        check("stop_low_fe", fe_cnt - fe0, 1);
        check("stop_low_no_push", rx_valid, 0);
        repeat (CPB) @(posedge clk); #1;

        // Short low glitch on an idle line
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk); #1;
        check("glitch_no_push", rx_valid, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);
        rx_q.push_back(8'h5A);
        rx_drive(make_frame(8'h5A, 1'b1));
        rx_pop("rx5a");

        // Reset in the middle of a frame whose current bit is low
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (39) @(posedge clk); #1;
        check("midframe_tx_low", tx, 0);
        rst = 1'b1;
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_tx_ready", tx_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tx_send(8'h81);

`ifdef UART_PARITY_EN
        tx_send(8'h07);
        fe0 = fe_cnt;
        fr = make_frame(8'h55, 1'b1);
        fr[DW+1] = ~fr[DW+1];
        rx_drive(fr);
        check("bad_parity_fe", fe_cnt - fe0, 1);
        check("bad_parity_no_push", rx_valid, 0);
        rx_q.push_back(8'h07);
        rx_drive(make_frame(8'h07, 1'b1));
        rx_pop("rx07_parity");
`endif

        check("rx_queue_consumed", rx_q.size(), 0);
        check("tx_queue_consumed", tx_bits_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
